prbs5_checker: RTL and testbench
================================

Name: prbs5_checker

Overview:
- Receive-side companion to the PRBS5 pattern generator used for link bring-up and BER testing.
- Takes the serial test bit stream back from the PHY/loopback path, self-synchronises to the PRBS5 sequence, declares lock, and counts bit errors.
- No seed exchange is needed: the next bit is predicted from received history.
- Sits after the RX deserialiser; `locked` and `err_cnt` feed the status registers.

Parameters:
- LOCK_CNT, 16: consecutive correct compared bits required to enter lock.
- WIN, 32: length of the lock-loss monitoring window, in compared bits.
- LOSS_ERR, 8: errors within one window that force loss of lock. Must be greater than 3.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  qualifies in_bit for this cycle
- in_bit  in  1  received PRBS bit
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  checker is synchronised to PRBS5
- err_pulse  out  1  one-cycle flag: last compared bit was in error (LOCKED only)
- err_cnt  out  ERR_W  saturating count of errors seen while LOCKED

Behaviour:
- Sequence definition:
  - Generator: Galois LFSR, seed 5'b11110, output = state bit 0.
  - Output recurrence: b[k] = b[k-3] ^ b[k-5]. Period 31.
  - Sequence starts 0,1,1,1,0,1,0,1,0,0,0,0,1,...
- All state advances only on cycles with in_valid=1. With in_valid=0, every register holds and err_pulse=0.
- History and comparison:
  - hist[4:0] holds the last 5 valid bits; hist[0] = b[k-1], hist[4] = b[k-5]. Received bits (not predictions) shift in.
  - fill counter 0..5 saturates. Compare is enabled only when fill==5.
  - err = in_bit ^ hist[2] ^ hist[4]. An all-zero hist also counts as err (guards the degenerate all-zero fixed point).
- FSM, state SEARCH:
  - Compared bit with err=0: good_run++.
  - Compared bit with err=1: good_run=0.
  - When good_run reaches LOCK_CNT, go to LOCKED. Clear win_pos and win_err.
  - No err_pulse and no counting while in SEARCH.
- FSM, state LOCKED:
  - Each compared bit: win_pos++. On err: win_err++, err_pulse=1, err_cnt++.
  - When win_pos completes WIN bits, win_pos=0 and win_err=0. An err on that final bit is counted, then cleared.
  - If win_err reaches LOSS_ERR, go to SEARCH and set good_run=0. The triggering error is still pulsed and counted.
- Consequence of self-synchronous checking: one flipped line bit yields exactly 3 errors, at bit k, k+3 and k+5.
- Latency:
  - err_pulse is registered and asserted the cycle after the offending valid bit.
  - locked rises the cycle after the LOCK_CNT-th good compare.
  - From reset on a clean stream, locked rises after valid bit 5+LOCK_CNT (21st).
- err_cnt:
  - Saturates at all-ones.
  - clr_cnt sets it to 0. clr_cnt wins over a simultaneous increment.
  - clr_cnt does not affect lock state.
- Reset (async): locked=0, err_pulse=0, err_cnt=0, state=SEARCH; fill, good_run, win_pos, win_err and hist all 0.
  - Reset mid-lock takes effect immediately; no pulse is produced.

Decomposition:
- Shared package prbs_pkg:
  - PRBS5 tap positions for both the Galois generator and the Fibonacci checker form.
  - PRBS5_SEED=5'b11110.
  - PRBS5_PERIOD=31.
  - State enum {SEARCH, LOCKED}.
- Sub-module prbs_win_monitor: window position/error counters and the loss-of-lock decision (inputs cmp_en, err, clr; output loss). The FSM, history and err_cnt stay in prbs5_checker.

Test Plan:
1. Reset, then the generator stream from seed 11110 with in_valid=1 continuously for 200 bits -> locked=1 the cycle after bit 21; err_pulse never high; err_cnt=0.
2. After lock, flip a single bit k -> err_pulse high the cycles after bits k, k+3 and k+5 only; err_cnt=3; locked stays 1.
3. After lock, invert 8 consecutive bits -> win_err reaches 8 within one window; locked drops the cycle after the 8th error; on clean resumption, locked returns after 5+16 clean valid bits.
4. 64 consecutive 0 bits after reset -> locked stays 0; err_cnt=0. Then a clean PRBS stream -> lock after 21 bits.
5. Clean stream with in_valid high every 3rd cycle -> lock after the 21st valid bit (cycle ~63). clr_cnt asserted in the same cycle as an error increment -> err_cnt=0.
6. Force err_cnt to all-ones via repeated errors (ERR_W=4 build) -> err_cnt holds 15. Assert rst_n=0 mid-lock -> locked and err_cnt go to 0 asynchronously.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS5 definitions: polynomial taps for the generator and the
// self-synchronous checker, seed, period and checker state encoding.
package prbs_pkg;

  // Galois generator: shift right, output bit 0, xor taps when output is 1.
  localparam logic [4:0] PRBS5_GALOIS_TAPS = 5'b10100;

  // Fibonacci checker form: predicted bit = hist[2] ^ hist[4],
  // i.e. b[k] = b[k-3] ^ b[k-5].
  localparam logic [4:0] PRBS5_FIB_TAPS = 5'b10100;

  localparam logic [4:0] PRBS5_SEED = 5'b11110;
  localparam int PRBS5_PERIOD = 31;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // Next bit predicted from the last five received bits.
  function automatic logic prbs5_predict(input logic [4:0] hist);
    return ^(hist & PRBS5_FIB_TAPS);
  endfunction

  // One step of the Galois generator (the output is state bit 0).
  function automatic logic [4:0] prbs5_galois_next(input logic [4:0] s);
    return (s >> 1) ^ (s[0] ? PRBS5_GALOIS_TAPS : 5'b00000);
  endfunction

endpackage

// File: rtl/prbs_win_monitor.sv
// Lock-loss monitor: counts compared bits and errors inside a fixed window
// and flags loss of lock when too many errors land in one window.
module prbs_win_monitor
  import prbs_pkg::*;
#(
  parameter int WIN      = 32,
  parameter int LOSS_ERR = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmp_en,
  input  logic err,
  input  logic clr,
  output logic loss
);

  localparam int POS_W = $clog2(WIN);
  localparam int ERR_CW = $clog2(LOSS_ERR + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN - 1);
  localparam logic [ERR_CW-1:0] ERR_LAST = ERR_CW'(LOSS_ERR - 1);

  logic [POS_W-1:0]  win_pos;
  logic [ERR_CW-1:0] win_err;

  // The triggering error is the one that would make win_err reach LOSS_ERR.
  assign loss = cmp_en && err && (win_err == ERR_LAST);

  // Window counters; the last bit of a window is counted before both clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_pos <= '0;
      win_err <= '0;
    end else if (clr) begin
      win_pos <= '0;
      win_err <= '0;
    end else if (cmp_en) begin
      if (loss || (win_pos == POS_LAST)) begin
        win_pos <= '0;
        win_err <= '0;
      end else begin
        win_pos <= win_pos + 1'b1;
        win_err <= win_err + ERR_CW'(err);
      end
    end
  end

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 receive checker: self-synchronises on the received bit history,
// declares lock after a run of good bits and counts errors while locked.
module prbs5_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 32,
  parameter int LOSS_ERR = 8,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GR_W = $clog2(LOCK_CNT + 1);
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(LOCK_CNT - 1);

  prbs_state_t     state;
  prbs_state_t     state_nxt;
  logic [4:0]      hist;
  logic [2:0]      fill;
  logic [GR_W-1:0] good_run;
  logic            cmp_en;
  logic            err;
  logic            lock_cmp;
  logic            good_hit;
  logic            loss;

  assign cmp_en   = in_valid && (fill == 3'd5);
  assign err      = (in_bit ^ prbs5_predict(hist)) | (hist == 5'b00000);
  assign lock_cmp = cmp_en && (state == LOCKED);
  assign good_hit = cmp_en && !err && (state == SEARCH) && (good_run == GR_LAST);
  assign locked   = (state == LOCKED);

  prbs_win_monitor #(
    .WIN      (WIN),
    .LOSS_ERR (LOSS_ERR)
  ) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmp_en (lock_cmp),
    .err    (err),
    .clr    (good_hit),
    .loss   (loss)
  );

  // Next-state: lock on a full good run, drop lock on window overflow.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (good_hit) state_nxt = LOCKED;
      LOCKED:  if (loss)     state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  // Received-bit history and fill level; predictions never enter the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= {hist[3:0], in_bit};
      if (fill != 3'd5) fill <= fill + 1'b1;
    end
  end

  // Consecutive good compares while searching; restarts after a lock loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_run <= '0;
    end else if (cmp_en && (state == SEARCH)) begin
      if (err || good_hit) good_run <= '0;
      else                 good_run <= good_run + 1'b1;
    end else if (loss) begin
      good_run <= '0;
    end
  end

  // Registered one-cycle error flag, only meaningful while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_pulse <= 1'b0;
    else        err_pulse <= lock_cmp && err;
  end

  // Saturating error counter; a software clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (lock_cmp && err && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// Self-checking bench for prbs5_checker: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_prbs5_checker;

  localparam int LOCK_CNT = 16;
  localparam int WIN      = 32;
  localparam int LOSS_ERR = 8;
  localparam int ERR_W    = 4;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  typedef struct {
    bit v;
    bit b;
    bit c;
    bit e_locked;
    bit e_pulse;
    int e_cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  bit seq[31];
  int sidx;

  bit m_hist[$];
  bit m_locked;
  bit m_pulse;
  int m_good;
  int m_wpos;
  int m_werr;
  int m_cnt;

  vec_t tbl[24];

  always #5 clk = ~clk;

  prbs5_checker #(
    .LOCK_CNT (LOCK_CNT),
    .WIN      (WIN),
    .LOSS_ERR (LOSS_ERR),
    .ERR_W    (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  function automatic void modelReset();
    m_hist.delete();
    m_locked = 0;
    m_pulse  = 0;
    m_good   = 0;
    m_wpos   = 0;
    m_werr   = 0;
    m_cnt    = 0;
  endfunction

  // Reference: error = received bit disagrees with b[k-3]^b[k-5] of the
  // received history, or the last five received bits were all zero.
  function automatic void modelStep(input bit v, input bit b, input bit c);
    bit e;
    bit any_one;
    m_pulse = 0;
    if (v) begin
      if (m_hist.size() == 5) begin
        any_one = 0;
        foreach (m_hist[i]) any_one |= m_hist[i];
        e = (b != (m_hist[2] ^ m_hist[0])) || !any_one;
        if (!m_locked) begin
          if (e) m_good = 0;
          else   m_good++;
          if (m_good == LOCK_CNT) begin
            m_locked = 1;
            m_good   = 0;
            m_wpos   = 0;
            m_werr   = 0;
          end
        end else begin
          m_wpos++;
          if (e) begin
            m_werr++;
            m_pulse = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
          if (m_werr == LOSS_ERR) begin
            m_locked = 0;
            m_good   = 0;
            m_wpos   = 0;
            m_werr   = 0;
          end else if (m_wpos == WIN) begin
            m_wpos = 0;
            m_werr = 0;
          end
        end
      end
      m_hist.push_back(b);
      if (m_hist.size() > 5) void'(m_hist.pop_front());
    end
    if (c) m_cnt = 0;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic checkOutput(input bit e_locked, input bit e_pulse, input int e_cnt, input string tag);
    checkValue({tag, ".locked"}, 32'(locked), 32'(e_locked));
    checkValue({tag, ".err_pulse"}, 32'(err_pulse), 32'(e_pulse));
    checkValue({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
  endtask

  // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input bit v, input bit b, input bit c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    modelStep(v, b, c);
  endtask

  task automatic prbsBit(input bit flip, input bit c, input string tag);
    applyStimulus(1'b1, seq[sidx % 31] ^ flip, c);
    sidx++;
    checkOutput(m_locked, m_pulse, m_cnt, tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    checkOutput(m_locked, m_pulse, m_cnt, tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(1'b0, 1'b0, 0, tag);
    @(negedge clk);
    rst_n = 1'b1;
    sidx  = 0;
  endtask

  initial begin
    int pmask;
    bit burst;
    bit v;
    bit b;

    seq[0] = 0; seq[1] = 1; seq[2] = 1; seq[3] = 1; seq[4] = 0;
    for (int k = 5; k < 31; k++) seq[k] = seq[k-3] ^ seq[k-5];

    for (int i = 0; i < 24; i++)
      tbl[i] = '{1'b1, seq[i], 1'b0, (i >= 5 + LOCK_CNT - 1), 1'b0, 0};

    // Test 1: clean stream from reset; lock after the 21st bit.
    doReset("t1_reset");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(tbl[i].v, tbl[i].b, tbl[i].c);
      sidx++;
      checkOutput(tbl[i].e_locked, tbl[i].e_pulse, tbl[i].e_cnt, $sformatf("t1_vec%0d", i));
    end
    for (int i = 24; i < 200; i++) prbsBit(1'b0, 1'b0, "t1_clean");
    checkValue("t1_locked", 32'(locked), 32'd1);
    checkValue("t1_cnt", 32'(err_cnt), 32'd0);

    // Test 2: one flipped bit gives errors at k, k+3, k+5.
    pmask = 0;
    for (int j = 0; j < 10; j++) begin
      prbsBit(j == 0, 1'b0, "t2_flip");
      if (err_pulse) pmask |= (1 << j);
    end
    checkValue("t2_pulse_positions", 32'(pmask), 32'd41);
    checkValue("t2_cnt", 32'(err_cnt), 32'd3);
    checkValue("t2_locked", 32'(locked), 32'd1);

    // Test 3: invert bits 55..62, all inside the window covering 53..84.
    doReset("t3_reset");
    for (int i = 0; i <= 100; i++) begin
      prbsBit((i >= 55) && (i <= 62), 1'b0, "t3_burst");
      if (i == 66) checkValue("t3_locked_before_8th", 32'(locked), 32'd1);
      if (i == 67) begin
        checkValue("t3_locked_after_8th", 32'(locked), 32'd0);
        checkValue("t3_cnt", 32'(err_cnt), 32'd8);
      end
      if (i == 82) checkValue("t3_relock_early", 32'(locked), 32'd0);
      if (i == 83) checkValue("t3_relock", 32'(locked), 32'd1);
    end

    // Test 4: all-zero input never locks; then a clean stream locks after 21.
    doReset("t4_reset");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(m_locked, m_pulse, m_cnt, "t4_zero");
    end
    checkValue("t4_zero_locked", 32'(locked), 32'd0);
    checkValue("t4_zero_cnt", 32'(err_cnt), 32'd0);
    sidx = 0;
    for (int i = 0; i < 25; i++) begin
      prbsBit(1'b0, 1'b0, "t4_prbs");
      if (i == 19) checkValue("t4_lock_early", 32'(locked), 32'd0);
      if (i == 20) checkValue("t4_lock", 32'(locked), 32'd1);
    end

    // Test 5: valid every third cycle, then clr_cnt against an increment.
    doReset("t5_reset");
    for (int i = 0; i < 30; i++) begin
      idleCycle("t5_idle");
      idleCycle("t5_idle");
      prbsBit(1'b0, 1'b0, "t5_sparse");
      if (i == 19) checkValue("t5_lock_early", 32'(locked), 32'd0);
      if (i == 20) checkValue("t5_lock", 32'(locked), 32'd1);
    end
    prbsBit(1'b1, 1'b1, "t5_clr_err");
    checkValue("t5_clr_wins_cnt", 32'(err_cnt), 32'd0);
    checkValue("t5_clr_err_pulse", 32'(err_pulse), 32'd1);
    for (int i = 0; i < 8; i++) prbsBit(1'b0, 1'b0, "t5_after_clr");
    checkValue("t5_cnt_after", 32'(err_cnt), 32'd2);

    // Test 6: saturate the counter, then reset asynchronously mid-lock.
    doReset("t6_reset");
    for (int i = 0; i < 30; i++) prbsBit(1'b0, 1'b0, "t6_lock");
    for (int f = 0; f < 6; f++) begin
      prbsBit(1'b1, 1'b0, "t6_flip");
      for (int i = 0; i < 39; i++) prbsBit(1'b0, 1'b0, "t6_clean");
    end
    checkValue("t6_saturated", 32'(err_cnt), 32'(CNT_MAX));
    checkValue("t6_locked", 32'(locked), 32'd1);
    prbsBit(1'b1, 1'b0, "t6_pre_reset");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(1'b0, 1'b0, 0, "t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sidx  = 0;

    // Randomized run: gaps, sparse flips, garbage bursts, random clears.
    burst = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ((cyc % 700) == 400) burst = 1;
      if ((cyc % 700) == 440) burst = 0;
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        if (burst) b = 1'($urandom_range(0, 1));
        else       b = seq[sidx % 31] ^ ($urandom_range(0, 39) == 0);
        sidx++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      applyStimulus(v, b, ($urandom_range(0, 149) == 0));
      checkOutput(m_locked, m_pulse, m_cnt, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
